// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared ops, FSM states and result-cache layout for muldiv_arbiter
package muldiv_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Cache entry packs {op, a, b, hi, lo} with lo in the least significant bits.
  function automatic int ce_width(int w);
    return 4 * w + 1;
  endfunction

  function automatic int ce_op_bit(int w);
    return 4 * w;
  endfunction

  function automatic int ce_a_lsb(int w);
    return 3 * w;
  endfunction

  function automatic int ce_b_lsb(int w);
    return 2 * w;
  endfunction

  function automatic int ce_hi_lsb(int w);
    return w;
  endfunction

  function automatic int rr_next(int idx, int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting the search at ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// rtl/muldiv_arbiter.sv - round-robin sharing of one iterative mul/div unit with a one-entry result cache
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_hi,
  output logic [W-1:0]      resp_lo,
  input  logic              flush,
  output logic              unit_start,
  output logic              unit_op,
  output logic [W-1:0]      unit_a,
  output logic [W-1:0]      unit_b,
  input  logic              unit_done,
  input  logic [W-1:0]      unit_hi,
  input  logic [W-1:0]      unit_lo,
  output logic              busy
);

  localparam int CEW   = ce_width(W);
  localparam int CE_OP = ce_op_bit(W);
  localparam int CE_A  = ce_a_lsb(W);
  localparam int CE_B  = ce_b_lsb(W);
  localparam int CE_HI = ce_hi_lsb(W);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, g_idx, id_q;
  logic [NREQ-1:0]  grant;
  logic             any_req, xfer, hit, div_zero;
  logic             op_q, cache_valid_q, sel_op, sel_op_q_unused;
  logic [W-1:0]     a_q, b_q, hi_q, lo_q, sel_a, sel_b;
  logic [CEW-1:0]   cache_q;
  logic [W-1:0]     a_arr [NREQ];
  logic [W-1:0]     b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (g_idx),
    .any   (any_req)
  );

  assign xfer      = !rst && (state_q == ST_IDLE) && any_req;
  assign req_ready = xfer ? grant : '0;
  assign sel_op    = req_op[g_idx];
  assign sel_a     = a_arr[g_idx];
  assign sel_b     = b_arr[g_idx];
  assign sel_op_q_unused = 1'b0;

  // Hit check sees the cache before any same-cycle flush takes effect.
  assign hit      = cache_valid_q && (cache_q[CE_OP] == sel_op) &&
                    (cache_q[CE_A +: W] == sel_a) && (cache_q[CE_B +: W] == sel_b);
  assign div_zero = (sel_op == OP_DIV) && (sel_b == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (xfer) state_d = (hit || div_zero) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (unit_done) state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      op_q          <= OP_MULT;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      cache_valid_q <= 1'b0;
      cache_q       <= '0;
    end else begin
      if (flush) cache_valid_q <= 1'b0;
      if (xfer) begin
        op_q     <= sel_op;
        a_q      <= sel_a;
        b_q      <= sel_b;
        id_q     <= g_idx;
        rr_ptr_q <= IDW'(rr_next(int'(g_idx), NREQ));
        if (hit) begin
          hi_q <= cache_q[CE_HI +: W];
          lo_q <= cache_q[W-1:0];
        end else if (div_zero) begin
          hi_q <= sel_a;
          lo_q <= '1;
        end
      end
      // A flush in the same cycle as the load leaves the entry invalid.
      if ((state_q == ST_BUSY) && unit_done) begin
        hi_q          <= unit_hi;
        lo_q          <= unit_lo;
        cache_q       <= {op_q, a_q, b_q, unit_hi, unit_lo};
        cache_valid_q <= !flush;
      end
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = id_q;
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;
  assign unit_start = (state_q == ST_BUSY) && !sel_op_q_unused;
  assign unit_op    = op_q;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb/tb_muldiv_arbiter.sv - randomized and directed self-checking bench for muldiv_arbiter
module tb_muldiv_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_op;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              resp_valid, resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_hi, resp_lo;
  logic              flush, unit_start, unit_op;
  logic [W-1:0]      unit_a, unit_b;
  logic              unit_done = 1'b0;
  logic [W-1:0]      unit_hi = '0, unit_lo = '0;
  logic              busy;

  muldiv_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_hi(resp_hi), .resp_lo(resp_lo), .flush(flush),
    .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_hi(unit_hi), .unit_lo(unit_lo), .busy(busy)
  );

  typedef struct packed { logic op; logic [W-1:0] a; logic [W-1:0] b; } rq_t;
  typedef struct packed { logic [IDW-1:0] id; logic [W-1:0] hi; logic [W-1:0] lo; int lat; } rs_t;
  typedef enum int {P_IDLE, P_RESP, P_ISSUE} ph_t;

  rq_t  rq_q [NREQ][$];
  rs_t  resp_log [$];
  int   grant_log [$];
  int   n_chk = 0, n_fail = 0;
  bit   acc [NREQ];
  bit   stray = 1'b0, known = 1'b0;
  int   unit_lat = 17, ucnt = 0, us_cycles = 0, hs_cnt = 0, cyc = 0;

  ph_t            m_ph = P_IDLE;
  int             m_ptr = 0, m_acc_cyc = 0;
  bit             m_cv = 1'b0;
  rq_t            m_c, m_cur;
  logic [IDW-1:0] m_id;
  logic [W-1:0]   m_hi, m_lo;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(logic [NREQ-1:0] v, int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Result the operation must produce, from plain arithmetic.
  function automatic logic [2*W-1:0] arith(rq_t r);
    logic [2*W-1:0] x, y;
    x = {{W{1'b0}}, r.a};
    y = {{W{1'b0}}, r.b};
    if (r.op == 1'b0) return x * y;
    if (r.b == '0) return {r.a, {W{1'b1}}};
    return {r.a % r.b, r.a / r.b};
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [2*W-1:0]  res;
    int              g;
    cyc++;
    // Iterative unit: done pulse in the unit_lat-th cycle of a held start.
    if (unit_start) begin ucnt++; us_cycles++; end
    else ucnt = 0;
    unit_done = stray || (unit_start && ucnt == unit_lat);
    if (unit_done && unit_start) begin
      res = arith({unit_op, unit_a, unit_b});
      unit_hi = res[2*W-1:W];
      unit_lo = res[W-1:0];
      ucnt = 0;
    end

    if (known) begin
      exp_rdy = '0;
      if (!rst && m_ph == P_IDLE) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) exp_rdy = NREQ'(1) << g;
      end
      check("req_ready", req_ready, exp_rdy);
      check("resp_valid", resp_valid, m_ph == P_RESP);
      check("busy", busy, m_ph != P_IDLE);
      check("unit_start", unit_start, m_ph == P_ISSUE);
      if (m_ph == P_RESP) begin
        check("resp_id", resp_id, m_id);
        check("resp_hi", resp_hi, m_hi);
        check("resp_lo", resp_lo, m_lo);
      end
      if (m_ph == P_ISSUE) begin
        check("unit_op", unit_op, m_cur.op);
        check("unit_a", unit_a, m_cur.a);
        check("unit_b", unit_b, m_cur.b);
      end
    end

    if (resp_valid && resp_ready && !rst) begin
      hs_cnt++;
      resp_log.push_back({resp_id, resp_hi, resp_lo, cyc - m_acc_cyc});
    end

    if (rst) begin
      m_ph = P_IDLE; m_ptr = 0; m_cv = 1'b0; known = 1'b1;
    end else begin
      case (m_ph)
        P_IDLE: begin
          g = pick(req_valid, m_ptr);
          if (g >= 0) begin
            m_cur = {req_op[g], W'(req_a >> (g*W)), W'(req_b >> (g*W))};
            m_id  = IDW'(g);
            res   = arith(m_cur);
            m_hi  = res[2*W-1:W];
            m_lo  = res[W-1:0];
            m_ptr = (g + 1) % NREQ;
            grant_log.push_back(g);
            acc[g] = 1'b1;
            m_acc_cyc = cyc;
            if (m_cv && m_c == m_cur) m_ph = P_RESP;
            else if (m_cur.op && m_cur.b == '0) m_ph = P_RESP;
            else m_ph = P_ISSUE;
          end
          if (flush) m_cv = 1'b0;
        end
        P_ISSUE: begin
          if (unit_done) begin m_ph = P_RESP; m_c = m_cur; m_cv = !flush; end
          else if (flush) m_cv = 1'b0;
        end
        default: begin
          if (resp_ready) m_ph = P_IDLE;
          if (flush) m_cv = 1'b0;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin req_valid[i] = 1'b0; acc[i] = 1'b0; end
      if (!req_valid[i] && rq_q[i].size() > 0) begin
        rq_t r = rq_q[i].pop_front();
        req_valid[i] = 1'b1;
        req_op[i] = r.op;
        req_a[i*W +: W] = r.a;
        req_b[i*W +: W] = r.b;
      end
    end
  endtask

  task automatic post(int i, logic op, logic [W-1:0] a, logic [W-1:0] b);
    rq_q[i].push_back({op, a, b});
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NREQ; i++)
      if (rq_q[i].size() > 0 || req_valid[i]) return 1'b0;
    return m_ph == P_IDLE;
  endfunction

  task automatic drain(int budget, string name);
    int n = 0;
    while (!all_idle() && n < budget) begin step(); n++; end
    check({name, " completes"}, 64'(all_idle()), 64'd1);
  endtask

  task automatic expect_last(string name, int id, logic [W-1:0] hi, logic [W-1:0] lo);
    rs_t r = (resp_log.size() > 0) ? resp_log[$] : '0;
    check({name, " id"}, r.id, id);
    check({name, " hi"}, r.hi, hi);
    check({name, " lo"}, r.lo, lo);
  endtask

  function automatic logic [W-1:0] pool();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 1;
      2: return 7;
      3: return 100;
      4: return '1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, base, hs0;
    rs_t r;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", req_ready, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_id", resp_id, 0);
    check("rst resp_hi", resp_hi, 0);
    check("rst resp_lo", resp_lo, 0);
    check("rst unit_start", unit_start, 0);
    check("rst unit_op", unit_op, 0);
    check("rst unit_a", unit_a, 0);
    check("rst unit_b", unit_b, 0);
    check("rst busy", busy, 0);
    rst = 1'b0;

    us_cycles = 0;
    post(0, 1'b0, 32'h0001_0000, 32'h0001_0000);
    drain(200, "mult");
    check("mult start cycles", us_cycles, 17);
    expect_last("mult", 0, 32'h1, 32'h0);

    us_cycles = 0;
    post(1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    drain(50, "hit");
    check("hit start cycles", us_cycles, 0);
    expect_last("hit", 1, 32'h1, 32'h0);
    r = (resp_log.size() > 0) ? resp_log[$] : '0;
    check("hit latency", r.lat, 1);

    flush = 1'b1; step(); flush = 1'b0;
    us_cycles = 0;
    post(0, 1'b0, 32'h0001_0000, 32'h0001_0000);
    drain(200, "flush reissue");
    check("flush reissue start cycles", us_cycles, 17);

    resp_ready = 1'b0;
    post(0, 1'b0, 32'd3, 32'd5);
    n = 0;
    while (!resp_valid && n < 100) begin step(); n++; end
    check("bp resp_valid seen", resp_valid, 1);
    post(1, 1'b0, 32'h1234, 32'h10);
    hs0 = hs_cnt;
    repeat (5) step();
    check("bp no handshake while held", hs_cnt - hs0, 0);
    resp_ready = 1'b1;
    step();
    check("bp single handshake", hs_cnt - hs0, 1);
    expect_last("bp", 0, 32'h0, 32'd15);
    drain(200, "bp");

    grant_log.delete();
    base = resp_log.size();
    unit_lat = 3;
    post(0, 1'b0, 32'd6, 32'd7);
    post(0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    post(1, 1'b1, 32'd100, 32'd7);
    post(1, 1'b0, 32'd9, 32'd9);
    drain(200, "rr");
    check("rr grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check("rr grant order", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
    r = (resp_log.size() > base + 1) ? resp_log[base + 1] : '0;
    check("rr div id", r.id, 1);
    check("rr div hi", r.hi, 2);
    check("rr div lo", r.lo, 14);
    r = (resp_log.size() > base + 2) ? resp_log[base + 2] : '0;
    check("rr wide mult hi", r.hi, 1);
    check("rr wide mult lo", r.lo, 32'hFFFF_FFFE);

    us_cycles = 0;
    post(0, 1'b1, 32'h0000_0007, 32'h0);
    drain(50, "div0");
    check("div0 start cycles", us_cycles, 0);
    expect_last("div0", 0, 32'h7, 32'hFFFF_FFFF);

    unit_lat = 40;
    post(0, 1'b1, 32'd1000, 32'd3);
    n = 0;
    while (!unit_start && n < 50) begin step(); n++; end
    check("rstbusy start seen", unit_start, 1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstbusy unit_start", unit_start, 0);
    check("rstbusy resp_valid", resp_valid, 0);
    check("rstbusy busy", busy, 0);
    base = resp_log.size();
    stray = 1'b1; step(); stray = 1'b0;
    repeat (3) step();
    check("stray done no response", resp_log.size(), base);
    check("stray done resp_valid", resp_valid, 0);
    unit_lat = 17;
    us_cycles = 0;
    post(1, 1'b0, 32'd9, 32'd9);
    drain(200, "post-reset cache");
    check("post-reset cache empty", us_cycles, 17);
    expect_last("post-reset", 1, 32'h0, 32'd81);

    for (int it = 0; it < 600; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (rq_q[i].size() < 2 && $urandom_range(0, 2) == 0)
          post(i, 1'($urandom_range(0, 1)), pool(), pool());
      resp_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      if (m_ph == P_IDLE) unit_lat = $urandom_range(1, 5);
      step();
    end
    flush = 1'b0;
    resp_ready = 1'b1;
    drain(3000, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
